// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } statetype;

   localparam int N_REQ  = 4;
   localparam int HOLD_W = 8;

   // One-hot grant vector for a requester index.
   function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic             valid,
   output logic [1:0]       idx
);

   logic [1:0]       cand [N_REQ];
   logic [N_REQ-1:0] hit;

   genvar gi;
   for (gi = 0; gi < N_REQ; gi++) begin : g_scan
      assign cand[gi] = ptr + 2'(gi);
      assign hit[gi]  = req[cand[gi]];
   end

   // Walk from the far end so the lowest scan offset overrides.
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (hit[i]) begin
            valid = 1'b1;
            idx   = cand[i];
         end
      end
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, hold limit and
// a mandatory idle gap between grants.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       owner,
   output logic             busy,
   output logic             timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   statetype          state_reg;
   logic [1:0]        ptr_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;

   logic              pick_valid;
   logic [1:0]        pick_idx;
   logic              voluntary;
   logic              hit_limit;
   logic              release_now;
   logic [HOLD_W-1:0] hold_cnt_next;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // A voluntary release (done or request drop) masks a coincident hold-limit expiry.
   assign voluntary     = done | ~req[owner];
   assign hit_limit     = (hold_cnt_reg == HOLD_LIM);
   assign release_now   = voluntary | hit_limit;
   assign hold_cnt_next = (hold_cnt_reg == '1) ? hold_cnt_reg : hold_cnt_reg + HOLD_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         ptr_reg      <= 2'd0;
         hold_cnt_reg <= '0;
         grant        <= '0;
         owner        <= 2'd0;
         busy         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               timeout <= 1'b0;
               if (pick_valid) begin
                  grant        <= onehot(pick_idx);
                  owner        <= pick_idx;
                  busy         <= 1'b1;
                  hold_cnt_reg <= '0;
                  state_reg    <= OWN;
               end
            end
            OWN: begin
               if (release_now) begin
                  grant     <= '0;
                  busy      <= 1'b0;
                  ptr_reg   <= owner + 2'd1;
                  timeout   <= hit_limit & ~voluntary;
                  state_reg <= GAP;
               end else begin
                  hold_cnt_reg <= hold_cnt_next;
               end
            end
            GAP: begin
               timeout   <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               grant     <= '0;
               busy      <= 1'b0;
               timeout   <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
